branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// One-cycle registered lookup, write-first bypass from the execute-stage update port.
module branch_predictor #(
    parameter int         ENTRIES   = 16,
    parameter logic [1:0] CTR_ALLOC = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        if_stall,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispred,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic            r_valid [ENTRIES];
    logic [TAGW-1:0] r_tag   [ENTRIES];
    logic [1:0]      r_ctr   [ENTRIES];
    logic [29:0]     r_tgt   [ENTRIES];

    logic        r_pred_hit;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic [31:0] r_br_count;
    logic [31:0] r_mispred_count;

    logic [IDXW-1:0] w_lk_idx;
    logic [TAGW-1:0] w_lk_tag;
    logic [IDXW-1:0] w_upd_idx;
    logic [TAGW-1:0] w_upd_tag;
    logic            w_upd_hit;
    logic            w_we;
    logic [1:0]      w_new_ctr;
    logic [29:0]     w_new_tgt;
    logic            w_byp;
    logic            w_lk_valid;
    logic [TAGW-1:0] w_lk_tagv;
    logic [1:0]      w_lk_ctr;
    logic [29:0]     w_lk_tgt;
    logic            w_lk_hit;
    logic            w_unused;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        logic [1:0] n;
        n = c;
        if (up) begin
            if (c != 2'b11) n = c + 2'b01;
        end else begin
            if (c != 2'b00) n = c - 2'b01;
        end
        return n;
    endfunction

    assign w_lk_idx  = if_pc[IDXW+1:2];
    assign w_lk_tag  = if_pc[31:IDXW+2];
    assign w_upd_idx = upd_pc[IDXW+1:2];
    assign w_upd_tag = upd_pc[31:IDXW+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_unused  = ^{if_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // Post-update contents of the entry addressed by the update port
    always_comb begin
        w_we      = 1'b0;
        w_new_ctr = r_ctr[w_upd_idx];
        w_new_tgt = r_tgt[w_upd_idx];
        if (upd_valid) begin
            if (w_upd_hit) begin
                w_we      = 1'b1;
                w_new_ctr = ctr_step(r_ctr[w_upd_idx], upd_taken);
                if (upd_taken) w_new_tgt = upd_target[31:2];
            end else if (upd_taken) begin
                w_we      = 1'b1;
                w_new_ctr = CTR_ALLOC;
                w_new_tgt = upd_target[31:2];
            end
        end
    end

    always_comb begin
        w_byp      = w_we && (w_lk_idx == w_upd_idx);
        w_lk_valid = w_byp ? 1'b1      : r_valid[w_lk_idx];
        w_lk_tagv  = w_byp ? w_upd_tag : r_tag[w_lk_idx];
        w_lk_ctr   = w_byp ? w_new_ctr : r_ctr[w_lk_idx];
        w_lk_tgt   = w_byp ? w_new_tgt : r_tgt[w_lk_idx];
        w_lk_hit   = w_lk_valid && (w_lk_tagv == w_lk_tag);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_ctr[i]   <= 2'b00;
                r_tgt[i]   <= '0;
            end
            r_pred_hit      <= 1'b0;
            r_pred_taken    <= 1'b0;
            r_pred_target   <= '0;
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_we) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_tag[w_upd_idx]   <= w_upd_tag;
                r_ctr[w_upd_idx]   <= w_new_ctr;
                r_tgt[w_upd_idx]   <= w_new_tgt;
            end
            if (!if_stall) begin
                r_pred_hit    <= w_lk_hit;
                r_pred_taken  <= w_lk_hit && w_lk_ctr[1];
                r_pred_target <= w_lk_hit ? {w_lk_tgt, 2'b00} : 32'h0;
            end
            if (upd_valid) begin
                r_br_count <= r_br_count + 32'd1;
                if (upd_mispred) r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign pred_hit      = r_pred_hit;
    assign pred_taken    = r_pred_taken;
    assign pred_target   = r_pred_target;
    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against a table-of-entries reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_stall;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 16 entries, index = word address mod 16, tag = pc / 64
    bit          m_val [16];
    bit   [31:0] m_tag [16];
    int          m_ctr [16];
    bit   [31:0] m_tgt [16];
    bit          e_hit;
    bit          e_taken;
    bit   [31:0] e_tgt;
    bit   [31:0] e_br;
    bit   [31:0] e_mis;

    branch_predictor #(.ENTRIES(16), .CTR_ALLOC(2'b10)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_pc        (if_pc),
        .if_stall     (if_stall),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_mispred  (upd_mispred),
        .br_count     (br_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge();
        int          i;
        bit   [31:0] t;
        if (!rst) begin
            for (int k = 0; k < 16; k++) begin
                m_val[k] = 0; m_tag[k] = 0; m_ctr[k] = 0; m_tgt[k] = 0;
            end
            e_hit = 0; e_taken = 0; e_tgt = 0; e_br = 0; e_mis = 0;
            return;
        end
        if (upd_valid) begin
            i = int'((upd_pc / 4) % 16);
            t = upd_pc / 64;
            if (m_val[i] && m_tag[i] == t) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = upd_target & ~32'h3;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (upd_taken) begin
                m_val[i] = 1; m_tag[i] = t; m_ctr[i] = 2; m_tgt[i] = upd_target & ~32'h3;
            end
            e_br = e_br + 1;
            if (upd_mispred) e_mis = e_mis + 1;
        end
        if (!if_stall) begin
            i = int'((if_pc / 4) % 16);
            e_hit   = m_val[i] && (m_tag[i] == if_pc / 64);
            e_taken = e_hit && (m_ctr[i] >= 2);
            e_tgt   = e_hit ? m_tgt[i] : 32'h0;
        end
    endtask

    task automatic cyc(input logic r, input logic st, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic um);
        rst = r; if_stall = st; if_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; upd_mispred = um;
        @(posedge clk);
        model_edge();
        #1;
        check("pred_hit", {31'b0, pred_hit}, {31'b0, e_hit});
        check("pred_taken", {31'b0, pred_taken}, {31'b0, e_taken});
        check("pred_target", pred_target, e_tgt);
        check("br_count", br_count, e_br);
        check("mispred_count", mispred_count, e_mis);
    endtask

    task automatic look(input logic [31:0] lpc);
        cyc(1, 0, lpc, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        cyc(1, 0, 32'h0, 1, upc, ut, utg, 0);
    endtask

    initial begin
        logic [31:0] pc_l, pc_u;
        cyc(0, 0, 32'h100, 1, 32'h100, 1, 32'h200, 1);
        cyc(0, 0, 32'h100, 0, 0, 0, 0, 0);
        check("rst_hit", {31'b0, pred_hit}, 32'h0);
        check("rst_br", br_count, 32'h0);

        look(32'h100);
        check("empty_hit", {31'b0, pred_hit}, 32'h0);
        upd(32'h100, 1, 32'h200);
        look(32'h100);
        check("alloc_hit", {31'b0, pred_hit}, 32'h1);
        check("alloc_target", pred_target, 32'h200);
        check("alloc_br", br_count, 32'h1);

        upd(32'h100, 0, 32'h0);
        upd(32'h100, 0, 32'h0);
        look(32'h100);
        check("dec_taken", {31'b0, pred_taken}, 32'h0);
        check("dec_target", pred_target, 32'h200);
        upd(32'h100, 0, 32'h0);
        for (int k = 0; k < 3; k++) upd(32'h100, 1, 32'h200);
        look(32'h100);
        check("sat_taken", {31'b0, pred_taken}, 32'h1);
        upd(32'h100, 0, 32'h0);
        look(32'h100);
        check("sat3_taken", {31'b0, pred_taken}, 32'h1);

        upd(32'h140, 1, 32'h300);
        look(32'h100);
        check("alias_old_hit", {31'b0, pred_hit}, 32'h0);
        look(32'h140);
        check("alias_new_target", pred_target, 32'h300);
        upd(32'h180, 0, 32'h0);
        look(32'h180);
        look(32'h140);

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'h100, 1, 32'h100, 1, 32'h204, 0);
        check("bypass_target", pred_target, 32'h204);
        cyc(1, 0, 32'h108, 1, 32'h108, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        look(32'h0);
        cyc(1, 1, 32'h100, 1, 32'h100, 1, 32'h204, 1);
        check("stall_hold", {31'b0, pred_hit}, 32'h0);
        look(32'h100);
        check("after_stall_hit", {31'b0, pred_hit}, 32'h1);
        cyc(1, 0, 32'h100, 0, 32'h100, 1, 32'h0, 1);
        check("mispred_no_valid", mispred_count, 32'h1);
        upd(32'h10C, 1, 32'h1000);
        upd(32'h14C, 1, 32'h2000);
        look(32'h10C);

        for (int n = 0; n < 3000; n++) begin
            pc_l = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            pc_u = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) pc_u = pc_l;
            if ($urandom_range(0, 7) == 0) begin
                pc_l = pc_l | 32'hABC00000;
                pc_u = pc_u | 32'hABC00000;
            end
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) == 0), pc_l,
                ($urandom_range(0, 2) != 0), pc_u, $urandom_range(0, 1) == 1,
                $urandom, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
